// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches single-cycle events into a level of WIDTH clken ticks with a GAP tick off-time.
module pulse_stretch #(
  parameter int   WIDTH    = 16,
  parameter int   GAP      = 2,
  parameter logic RETRIG   = 1'b0,
  parameter logic POLARITY = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clken,
  input  logic i,
  output logic o,
  output logic busy,
  output logic ovf
);
  localparam int MX = WIDTH > GAP ? WIDTH : GAP;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] WL = CW'(WIDTH);
  localparam logic [CW-1:0] GL = CW'(GAP);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAPS} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic pending;
  logic ev, pend_eff, term;
  // an event that does not retrigger is queued; a second one while queued is dropped
  assign ev = i && state != IDLE && !(RETRIG && state == ACTIVE);
  assign pend_eff = pending | ev;
  assign term = clken && cnt == ONE;
  assign busy = state != IDLE || pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pending <= 1'b0;
      ovf <= 1'b0;
      o <= ~POLARITY;
    end else begin
      if (ev && pending) ovf <= 1'b1;
      case (state)
        IDLE: if (i) begin
          state <= ACTIVE;
          cnt <= WL;
          o <= POLARITY;
        end
        ACTIVE: if (i && RETRIG) cnt <= WL;
        else if (term && GAP > 0) begin
          state <= GAPS;
          cnt <= GL;
          o <= ~POLARITY;
          pending <= pend_eff;
        end else if (term) begin
          state <= pend_eff ? ACTIVE : IDLE;
          cnt <= pend_eff ? WL : '0;
          o <= pend_eff ? POLARITY : ~POLARITY;
          pending <= 1'b0;
        end else begin
          pending <= pend_eff;
          if (clken) cnt <= cnt - ONE;
        end
        GAPS: if (term) begin
          state <= pend_eff ? ACTIVE : IDLE;
          cnt <= pend_eff ? WL : '0;
          o <= pend_eff ? POLARITY : ~POLARITY;
          pending <= 1'b0;
        end else begin
          pending <= pend_eff;
          if (clken) cnt <= cnt - ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: five differently parameterised instances on shared stimulus, checked against plan constants and a tick-count model.
module tb_pulse_stretch;
  localparam int W0 = 4, W1 = 3, W2 = 8, W3 = 2, W4 = 10;
  localparam int G0 = 2, G1 = 2, G2 = 2, G3 = 0, G4 = 2;
  logic clk = 0, rst = 1, clken = 1, i = 0;
  logic [4:0] o_v, busy_v, ovf_v;
  int n_cmp = 0, n_bad = 0;
  int w_a [5] = '{W0, W1, W2, W3, W4};
  int g_a [5] = '{G0, G1, G2, G3, G4};
  bit rt_a [5] = '{0, 0, 1, 0, 0};
  bit p_a [5] = '{1, 1, 1, 1, 0};
  typedef struct {int on; int off; int q; bit ov;} mst_t;
  mst_t ms [5];

  pulse_stretch #(.WIDTH(W0), .GAP(G0), .RETRIG(1'b0), .POLARITY(1'b1)) u0 (.clk(clk), .rst(rst), .clken(clken), .i(i), .o(o_v[0]), .busy(busy_v[0]), .ovf(ovf_v[0]));
  pulse_stretch #(.WIDTH(W1), .GAP(G1), .RETRIG(1'b0), .POLARITY(1'b1)) u1 (.clk(clk), .rst(rst), .clken(clken), .i(i), .o(o_v[1]), .busy(busy_v[1]), .ovf(ovf_v[1]));
  pulse_stretch #(.WIDTH(W2), .GAP(G2), .RETRIG(1'b1), .POLARITY(1'b1)) u2 (.clk(clk), .rst(rst), .clken(clken), .i(i), .o(o_v[2]), .busy(busy_v[2]), .ovf(ovf_v[2]));
  pulse_stretch #(.WIDTH(W3), .GAP(G3), .RETRIG(1'b0), .POLARITY(1'b1)) u3 (.clk(clk), .rst(rst), .clken(clken), .i(i), .o(o_v[3]), .busy(busy_v[3]), .ovf(ovf_v[3]));
  pulse_stretch #(.WIDTH(W4), .GAP(G4), .RETRIG(1'b0), .POLARITY(1'b0)) u4 (.clk(clk), .rst(rst), .clken(clken), .i(i), .o(o_v[4]), .busy(busy_v[4]), .ovf(ovf_v[4]));

  initial forever #5 clk = ~clk;
  initial assert (W0 >= 1 && W1 >= 1 && W2 >= 1 && W3 >= 1 && W4 >= 1) else $fatal(1, "FAIL width_param WIDTH must be >= 1");

  // model: remaining on-ticks, remaining off-ticks, queued events, dropped-event flag
  function automatic mst_t step(mst_t s, bit r, bit ce, bit ev, int w, int g, bit rt);
    mst_t n = s;
    if (r) return '{0, 0, 0, 1'b0};
    if (s.on > 0) begin
      if (ev && rt) n.on = w;
      else begin
        if (ev) begin if (s.q > 0) n.ov = 1; else n.q = 1; end
        if (ce && s.on == 1) begin
          n.on = 0;
          if (g > 0) n.off = g;
          else if (n.q > 0) begin n.on = w; n.q = 0; end
        end else if (ce) n.on = s.on - 1;
      end
    end else if (s.off > 0) begin
      if (ev) begin if (s.q > 0) n.ov = 1; else n.q = 1; end
      if (ce && s.off == 1) begin
        n.off = 0;
        if (n.q > 0) begin n.on = w; n.q = 0; end
      end else if (ce) n.off = s.off - 1;
    end else if (ev) n.on = w;
    return n;
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 5; k++) ms[k] <= step(ms[k], rst, clken, i, w_a[k], g_a[k], rt_a[k]);

  task automatic cyc(input bit r, input bit ce, input bit ii);
    rst = r; clken = ce; i = ii;
    @(negedge clk);
  endtask

  task automatic test_reset;
    cyc(1, 1, 1); cyc(1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      n_cmp += 3;
      if (o_v[k] !== !p_a[k]) begin n_bad++; $display("FAIL reset_o u%0d got=%b exp=%b", k, o_v[k], !p_a[k]); end
      if (busy_v[k] !== 1'b0) begin n_bad++; $display("FAIL reset_busy u%0d got=%b exp=0", k, busy_v[k]); end
      if (ovf_v[k] !== 1'b0) begin n_bad++; $display("FAIL reset_ovf u%0d got=%b exp=0", k, ovf_v[k]); end
    end
  endtask

  task automatic test_basic;
    cyc(1, 1, 0);
    for (int c = 0; c < 20; c++) begin
      int n = c + 1;
      bit eo = n >= 11 && n <= 14, eb = n >= 11 && n <= 16;
      cyc(0, 1, c == 10);
      n_cmp += 3;
      if (o_v[0] !== eo) begin n_bad++; $display("FAIL basic_o cyc=%0d got=%b exp=%b", n, o_v[0], eo); end
      if (busy_v[0] !== eb) begin n_bad++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", n, busy_v[0], eb); end
      if (ovf_v[0] !== 1'b0) begin n_bad++; $display("FAIL basic_ovf cyc=%0d got=%b exp=0", n, ovf_v[0]); end
    end
  endtask

  task automatic test_enable;
    cyc(1, 1, 0);
    for (int c = 0; c < 22; c++) begin
      int n = c + 1;
      bit eo = n >= 1 && n <= 11, eb = n >= 1 && n <= 19;
      cyc(0, c % 4 == 3, c == 0);
      n_cmp += 2;
      if (o_v[1] !== eo) begin n_bad++; $display("FAIL enable_o cyc=%0d got=%b exp=%b", n, o_v[1], eo); end
      if (busy_v[1] !== eb) begin n_bad++; $display("FAIL enable_busy cyc=%0d got=%b exp=%b", n, busy_v[1], eb); end
    end
  endtask

  task automatic test_retrigger;
    cyc(1, 1, 0);
    for (int c = 0; c < 18; c++) begin
      int n = c + 1;
      bit eo = n >= 1 && n <= 13, eb = n >= 1 && n <= 15;
      cyc(0, 1, c == 0 || c == 5);
      n_cmp += 3;
      if (o_v[2] !== eo) begin n_bad++; $display("FAIL retrig_o cyc=%0d got=%b exp=%b", n, o_v[2], eo); end
      if (busy_v[2] !== eb) begin n_bad++; $display("FAIL retrig_busy cyc=%0d got=%b exp=%b", n, busy_v[2], eb); end
      if (ovf_v[2] !== 1'b0) begin n_bad++; $display("FAIL retrig_ovf cyc=%0d got=%b exp=0", n, ovf_v[2]); end
    end
  endtask

  task automatic test_pending;
    cyc(1, 1, 0);
    for (int c = 0; c < 16; c++) begin
      int n = c + 1;
      bit eo = (n >= 1 && n <= 4) || (n >= 7 && n <= 10), eb = n >= 1 && n <= 12, ev = n >= 4;
      cyc(0, 1, c == 0 || c == 2 || c == 3);
      n_cmp += 3;
      if (o_v[0] !== eo) begin n_bad++; $display("FAIL pending_o cyc=%0d got=%b exp=%b", n, o_v[0], eo); end
      if (busy_v[0] !== eb) begin n_bad++; $display("FAIL pending_busy cyc=%0d got=%b exp=%b", n, busy_v[0], eb); end
      if (ovf_v[0] !== ev) begin n_bad++; $display("FAIL pending_ovf cyc=%0d got=%b exp=%b", n, ovf_v[0], ev); end
    end
  endtask

  task automatic test_back_to_back;
    cyc(1, 1, 0);
    for (int c = 0; c < 8; c++) begin
      int n = c + 1;
      bit eo = n >= 1 && n <= 4;
      cyc(0, 1, c == 0 || c == 1);
      n_cmp += 3;
      if (o_v[3] !== eo) begin n_bad++; $display("FAIL b2b_o cyc=%0d got=%b exp=%b", n, o_v[3], eo); end
      if (busy_v[3] !== eo) begin n_bad++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", n, busy_v[3], eo); end
      if (ovf_v[3] !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf cyc=%0d got=%b exp=0", n, ovf_v[3]); end
    end
  endtask

  task automatic test_reset_mid;
    cyc(1, 1, 0);
    for (int c = 0; c < 20; c++) begin
      int n = c + 1;
      bit act = n >= 1 && n <= 4;
      cyc(c == 4, 1, c == 0 || c == 4);
      n_cmp += 3;
      if (o_v[4] !== !act) begin n_bad++; $display("FAIL rstmid_o cyc=%0d got=%b exp=%b", n, o_v[4], !act); end
      if (busy_v[4] !== act) begin n_bad++; $display("FAIL rstmid_busy cyc=%0d got=%b exp=%b", n, busy_v[4], act); end
      if (ovf_v[4] !== 1'b0) begin n_bad++; $display("FAIL rstmid_ovf cyc=%0d got=%b exp=0", n, ovf_v[4]); end
    end
  endtask

  task automatic test_random;
    int dens [3] = '{10, 40, 85};
    cyc(1, 1, 0);
    for (int c = 0; c < 3000; c++) begin
      int d = dens[(c / 500) % 3];
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 99) < ((c / 250) % 2 ? 100 : 45), $urandom_range(0, 99) < d);
      for (int k = 0; k < 5; k++) begin
        bit eo = ms[k].on > 0 ? p_a[k] : !p_a[k];
        bit eb = ms[k].on > 0 || ms[k].off > 0 || ms[k].q > 0;
        n_cmp += 3;
        if (o_v[k] !== eo) begin n_bad++; $display("FAIL rand_o u%0d cyc=%0d got=%b exp=%b", k, c, o_v[k], eo); end
        if (busy_v[k] !== eb) begin n_bad++; $display("FAIL rand_busy u%0d cyc=%0d got=%b exp=%b", k, c, busy_v[k], eb); end
        if (ovf_v[k] !== ms[k].ov) begin n_bad++; $display("FAIL rand_ovf u%0d cyc=%0d got=%b exp=%b", k, c, ovf_v[k], ms[k].ov); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_enable;
    test_retrigger;
    test_pending;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
